// File: rtl/char_stream_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : char_stream_arbiter_pkg
// Brief    : Shared character codes, FSM encoding and defaults for the arbiter.
// Revision : 1.0
// ============================================================================
package char_stream_arbiter_pkg;

   localparam logic [7:0] CHAR_SOF  = 8'h5E;   // '^'
   localparam logic [7:0] CHAR_EOF  = 8'h23;   // '#'
   localparam logic [7:0] CHAR_IDLE = 8'h00;

   localparam int DEF_N_SRC   = 4;
   localparam int DEF_TIMEOUT = 16;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/char_stream_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Brief    : Returns the first set request at or after ptr, wrapping circularly.
// Revision : 1.0
// ============================================================================
module rr_picker #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] grant,
   output logic         any
);

   // One extra bit so ptr+k never overflows before the modulo fold.
   logic [W:0] idx;

   always_comb begin
      grant = '0;
      any   = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = {1'b0, ptr} + (W+1)'(k);
         if (idx >= (W+1)'(N)) begin
            idx = idx - (W+1)'(N);
         end
         if (!any && req[idx[W-1:0]]) begin
            any   = 1'b1;
            grant = idx[W-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/char_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : char_stream_arbiter
// Brief    : Round-robin record arbiter merging N trace-character streams.
// Revision : 1.0
// ============================================================================
module char_stream_arbiter
   import char_stream_arbiter_pkg::*;
#(
   parameter int N_SRC   = DEF_N_SRC,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [8*N_SRC-1:0]         src_char,
   input  logic [N_SRC-1:0]           src_valid,
   output logic [N_SRC-1:0]           src_ready,
   output logic [7:0]                 out_char,
   output logic                       out_valid,
   output logic [$clog2(N_SRC)-1:0]   owner,
   output logic                       rec_done,
   output logic                       abort,
   output logic [15:0]                drop_cnt
);

   localparam int SRC_W = $clog2(N_SRC);

   state_t             state_q, state_d;
   logic [SRC_W-1:0]   rr_q, rr_d;
   logic [SRC_W-1:0]   owner_q, owner_d;
   logic [7:0]         stall_q, stall_d;
   logic [7:0]         out_char_q, out_char_d;
   logic               out_valid_q, out_valid_d;
   logic               rec_done_q, rec_done_d;
   logic               abort_q, abort_d;
   logic [15:0]        drop_q, drop_d;

   logic [N_SRC-1:0]   w_cand;
   logic [3:0]         w_drop_inc;
   logic [16:0]        w_drop_sum;
   logic [SRC_W-1:0]   w_grant;
   logic               w_any;
   logic [7:0]         w_own_char;
   logic               w_own_valid;
   logic               w_timeout;

   always_comb begin
      w_cand     = '0;
      w_drop_inc = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (src_valid[i]) begin
            if (src_char[8*i +: 8] == CHAR_SOF) begin
               w_cand[i] = 1'b1;
            end else begin
               w_drop_inc = w_drop_inc + 4'd1;
            end
         end
      end
   end

   rr_picker #(
      .N (N_SRC),
      .W (SRC_W)
   ) u_rr_picker (
      .req   (w_cand),
      .ptr   (rr_q),
      .grant (w_grant),
      .any   (w_any)
   );

   assign w_own_char  = src_char[8*owner_q +: 8];
   assign w_own_valid = src_valid[owner_q];
   assign w_timeout   = (state_q == ST_LOCK) && !w_own_valid && (stall_q == 8'(TIMEOUT - 1));
   assign w_drop_sum  = {1'b0, drop_q} + 17'(w_drop_inc);

   // Losing '^' candidates are back-pressured so they survive to the next round.
   always_comb begin
      src_ready = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (state_q == ST_IDLE) begin
            src_ready[i] = src_valid[i] && (!w_cand[i] || (w_any && (w_grant == SRC_W'(i))));
         end else begin
            src_ready[i] = (owner_q == SRC_W'(i)) && !w_timeout;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      owner_d     = owner_q;
      stall_d     = stall_q;
      out_char_d  = CHAR_IDLE;
      out_valid_d = 1'b0;
      rec_done_d  = 1'b0;
      abort_d     = 1'b0;
      drop_d      = drop_q;
      case (state_q)
         ST_IDLE: begin
            drop_d = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            if (w_any) begin
               state_d     = ST_LOCK;
               owner_d     = w_grant;
               rr_d        = (w_grant == SRC_W'(N_SRC - 1)) ? '0 : w_grant + 1'b1;
               stall_d     = '0;
               out_char_d  = CHAR_SOF;
               out_valid_d = 1'b1;
            end
         end
         ST_LOCK: begin
            if (w_own_valid) begin
               stall_d     = '0;
               out_char_d  = w_own_char;
               out_valid_d = 1'b1;
               if (w_own_char == CHAR_EOF) begin
                  rec_done_d = 1'b1;
                  state_d    = ST_IDLE;
               end
            end else if (w_timeout) begin
               stall_d     = '0;
               out_char_d  = CHAR_IDLE;
               out_valid_d = 1'b1;
               abort_d     = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               stall_d = stall_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         rr_q        <= '0;
         owner_q     <= '0;
         stall_q     <= '0;
         out_char_q  <= CHAR_IDLE;
         out_valid_q <= 1'b0;
         rec_done_q  <= 1'b0;
         abort_q     <= 1'b0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         owner_q     <= owner_d;
         stall_q     <= stall_d;
         out_char_q  <= out_char_d;
         out_valid_q <= out_valid_d;
         rec_done_q  <= rec_done_d;
         abort_q     <= abort_d;
         drop_q      <= drop_d;
      end
   end

   assign out_char  = out_char_q;
   assign out_valid = out_valid_q;
   assign owner     = owner_q;
   assign rec_done  = rec_done_q;
   assign abort     = abort_q;
   assign drop_cnt  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_char_stream_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_char_stream_arbiter
// Brief    : Scoreboard bench for char_stream_arbiter with directed records.
// Revision : 1.0
// ============================================================================
module tb_char_stream_arbiter;
   import char_stream_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int TO = 16;

   logic           clk       = 1'b0;
   logic           reset_n   = 1'b0;
   logic [8*N-1:0] src_char  = '0;
   logic [N-1:0]   src_valid = '0;
   logic [N-1:0]   src_ready;
   logic [7:0]     out_char;
   logic           out_valid;
   logic [1:0]     owner;
   logic           rec_done;
   logic           abort;
   logic [15:0]    drop_cnt;

   always #5 clk = ~clk;

   char_stream_arbiter #(
      .N_SRC   (N),
      .TIMEOUT (TO)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .src_char  (src_char),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .out_char  (out_char),
      .out_valid (out_valid),
      .owner     (owner),
      .rec_done  (rec_done),
      .abort     (abort),
      .drop_cnt  (drop_cnt)
   );

   typedef struct packed {
      logic [7:0] c;
      logic       done;
      logic       ab;
      logic [1:0] own;
   } exp_t;

   exp_t expq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   t_sof  = 0;
   int   t_eof  = 0;
   int   t_prev = 0;
   int   abort_gap = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops the scoreboard on each valid output, checks idle cycles otherwise.
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (out_valid) begin
               checks++;
               if (expq.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_out actual char=%h done=%b abort=%b owner=%0d required none",
                           out_char, rec_done, abort, owner);
               end else begin
                  exp_t e;
                  e = expq.pop_front();
                  if ({out_char, rec_done, abort, owner} !== e) begin
                     errors++;
                     $display("FAIL stream actual char=%h done=%b abort=%b owner=%0d required char=%h done=%b abort=%b owner=%0d",
                              out_char, rec_done, abort, owner, e.c, e.done, e.ab, e.own);
                  end
               end
               if (abort)              abort_gap = cyc - t_prev;
               if (out_char == CHAR_SOF) t_sof = cyc;
               if (out_char == CHAR_EOF) t_eof = cyc;
               t_prev = cyc;
            end else begin
               checks++;
               if (out_char !== 8'h00 || rec_done !== 1'b0 || abort !== 1'b0) begin
                  errors++;
                  $display("FAIL idle_outputs actual char=%h done=%b abort=%b required 00/0/0",
                           out_char, rec_done, abort);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic put(input int s, input logic [7:0] c);
      bit ok;
      ok = 1'b0;
      src_char[8*s +: 8] = c;
      src_valid[s]       = 1'b1;
      for (int k = 0; k < 300 && !ok; k++) begin
         @(negedge clk);
         if (src_ready[s]) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
         end
      end
      src_valid[s] = 1'b0;
      if (!ok) begin
         errors++;
         $display("FAIL accept_timeout src=%0d actual char %h not accepted required accept within 300 cycles", s, c);
      end
   endtask

   task automatic send_str(input int s, input string str);
      for (int i = 0; i < str.len(); i++) put(s, str[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic exp_str(input string str, input int own);
      exp_t e;
      for (int i = 0; i < str.len(); i++) begin
         e.c    = str[i];
         e.done = (str[i] == CHAR_EOF);
         e.ab   = 1'b0;
         e.own  = own[1:0];
         expq.push_back(e);
      end
   endtask

   task automatic exp_abort(input int own);
      exp_t e;
      e.c    = 8'h00;
      e.done = 1'b0;
      e.ab   = 1'b1;
      e.own  = own[1:0];
      expq.push_back(e);
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && expq.size() != 0; k++) @(posedge clk);
      idle(3);
      chk("drain_queue_empty", expq.size(), 0);
   endtask

   localparam string S1 = "^12@00003000: $3 <= 0000000a#";

   initial begin
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_char",  out_char,  8'h00);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_owner",     owner,     0);
      chk("rst_rec_done",  rec_done,  0);
      chk("rst_abort",     abort,     0);
      chk("rst_drop_cnt",  drop_cnt,  0);
      reset_n = 1'b1;

      // Simultaneous '^' on 0 and 2 with pointer at 0: 0 first, 2 held then served.
      exp_str("^AB#", 0);
      exp_str("^CD#", 2);
      fork
         send_str(0, "^AB#");
         send_str(2, "^CD#");
      join
      drain();

      // Pointer now 3: source 3 beats source 1; an inner '^' does not end the record.
      exp_str("^k#", 3);
      exp_str("^a^b#", 1);
      fork
         send_str(1, "^a^b#");
         send_str(3, "^k#");
      join
      drain();

      exp_str(S1, 0);
      send_str(0, S1);
      drain();
      chk("throughput_span", t_eof - t_sof, S1.len() - 1);

      // 15 stall cycles stays just under the timeout.
      exp_str("^xy#", 0);
      send_str(0, "^x");
      idle(TO - 1);
      send_str(0, "y#");
      drain();
      chk("drop_cnt_none", drop_cnt, 0);

      exp_str("^z#", 1);
      send_str(1, "ab");
      send_str(1, "^z#");
      drain();
      chk("drop_cnt_two", drop_cnt, 2);

      exp_str("^12", 2);
      exp_abort(2);
      exp_str("^w#", 0);
      send_str(2, "^12");
      idle(TO + 2);
      send_str(0, "^w#");
      drain();
      chk("abort_gap", abort_gap, TO);

      // Asynchronous reset mid-record from source 2.
      exp_str("^mi", 2);
      send_str(2, "^mi");
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_out_char",  out_char,  8'h00);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_owner",     owner,     0);
      chk("arst_rec_done",  rec_done,  0);
      chk("arst_abort",     abort,     0);
      chk("arst_drop_cnt",  drop_cnt,  0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Pointer back at 0 after reset: source 1 wins over 3, then 3 follows.
      exp_str("^r#", 1);
      exp_str("^q#", 3);
      fork
         send_str(3, "^q#");
         send_str(1, "^r#");
      join
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/char_stream_arbiter.md
CHAR_STREAM_ARBITER -- requirements
Module: char_stream_arbiter

Interface
REQ-001 Parameter N_SRC, default 4, SHALL set the number of trace-character sources (2..8).
REQ-002 Parameter TIMEOUT, default 16, SHALL set the number of owner stall cycles that abort a record (1..255).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 src_char  input  8*N_SRC  SHALL carry one ASCII character per source; source i occupies bits [8i+7:8i].
REQ-006 src_valid  input  N_SRC  SHALL mark src_char[i] as valid.
REQ-007 src_ready  output  N_SRC  SHALL be combinational; a character transfers on any cycle where src_valid[i] and src_ready[i] are both 1.
REQ-008 out_char  output  8  SHALL be the registered character presented to the format checker.
REQ-009 out_valid  output  1  SHALL be registered; the checker consumes out_char only when out_valid=1.
REQ-010 owner  output  clog2(N_SRC)  SHALL identify the source of the record currently being forwarded.
REQ-011 rec_done  output  1  SHALL pulse one cycle, aligned with out_char='#'.
REQ-012 abort  output  1  SHALL pulse one cycle, aligned with the injected abort character.
REQ-013 drop_cnt  output  16  SHALL count characters discarded outside records; it saturates at 16'hFFFF.

Function
REQ-014 FSM states SHALL be IDLE and LOCK.
REQ-015 In IDLE, src_ready[i] SHALL be 1 for every source with src_valid[i]=1.
  - a source presenting '^' is a candidate;
  - a source presenting any other character has it discarded, and drop_cnt increments by the number discarded that cycle.
REQ-016 In IDLE with at least one candidate, the winner SHALL be the first candidate at or after rr_ptr (circular).
  - next cycle: out_char='^', out_valid=1, owner=winner, state=LOCK;
  - rr_ptr=winner+1 mod N_SRC.
REQ-017 Losing candidates in IDLE SHALL have src_ready=0, so their '^' is held, not dropped.
REQ-018 In LOCK, src_ready SHALL be 1 only for owner, and 0 for all other sources.
  - each accepted owner character appears on out_char with out_valid=1 exactly one cycle later;
  - a cycle with no owner transfer gives out_valid=0 next cycle.
REQ-019 In LOCK, an accepted '#' SHALL end the record: rec_done pulses with its output, and state returns to IDLE.
REQ-020 In LOCK, an accepted '^' SHALL be forwarded unchanged and SHALL NOT end the record; the checker resynchronises.
REQ-021 A stall counter SHALL clear on every owner transfer and increment on each LOCK cycle with src_valid[owner]=0.
  - on reaching TIMEOUT, next cycle: out_char=8'h00, out_valid=1, abort=1, state=IDLE;
  - src_ready[owner]=0 in the timeout cycle.
REQ-022 A LOCK-to-IDLE transition SHALL take effect for arbitration on the following cycle; there is no same-cycle regrant.
REQ-023 Throughput SHALL be one character per cycle while the owner streams continuously.
REQ-024 When out_valid=0, out_char SHALL hold 8'h00.

Reset
REQ-025 Asserting reset_n=0 SHALL immediately force the following, regardless of any record in flight:
  - state=IDLE, rr_ptr=0, stall counter=0;
  - out_char=8'h00, out_valid=0, owner=0, rec_done=0, abort=0, drop_cnt=0.
REQ-026 Deassertion SHALL be synchronised externally; the first arbitration occurs on the first rising edge with reset_n=1.

Structure
REQ-027 A shared package SHALL hold:
  - the character constants '^', '#', and idle 8'h00;
  - the FSM state encoding;
  - the default N_SRC and TIMEOUT.
REQ-028 The circular first-at-or-after selection SHALL be a sub-module rr_picker, with inputs req vector and ptr, and outputs grant index and any.

Verification
REQ-029 Single source 0 streams "^12@00003000: $3 <= 0000000a#" -> identical out_char sequence at 1-cycle latency, rec_done with '#', owner=0, abort never set.
REQ-030 Sources 0 and 2 present '^' in the same IDLE cycle with rr_ptr=0 -> source 0 granted, and source 2's record follows immediately after source 0's '#' with no interleaving.
REQ-031 Source 1 sends "ab" in IDLE, then a record -> drop_cnt=2, record forwarded intact.
REQ-032 Owner stalls 16 cycles mid-record with TIMEOUT=16 -> out_char=8'h00 with abort=1, state IDLE, next '^' from any source granted.
REQ-033 reset_n pulled low mid-record -> all outputs zero asynchronously; after release, a fresh record from source 3 is forwarded with owner=3.
